// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXE/MEM/WB, drives datapath
// enables and selects, and counts retired instructions.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             IRWr,
    output logic             PCWr,
    output logic [1:0]       NPCSel,
    output logic             GRFWr,
    output logic [1:0]       RegDst,
    output logic [1:0]       WDSel,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic [1:0]       EOp,
    output logic             DMWr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL
    } instr_t;

    state_t     st;
    state_t     st_nxt;
    instr_t     ins;
    logic [1:0] ins_eop;
    logic [2:0] ins_aluop;
    logic       ins_alusrc;
    logic [1:0] ins_regdst;

    // Instruction classification from the IR fields
    always_comb begin
        ins = I_NOP;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: ins = I_ADDU;
                    6'b100011: ins = I_SUBU;
                    6'b001000: ins = I_JR;
                    default:   ins = I_NOP;
                endcase
            end
            6'b001101: ins = I_ORI;
            6'b001111: ins = I_LUI;
            6'b100011: ins = I_LW;
            6'b101011: ins = I_SW;
            6'b000100: ins = I_BEQ;
            6'b000011: ins = I_JAL;
            default:   ins = I_NOP;
        endcase
    end

    // Per-instruction datapath settings held from DECODE/EXE through WB
    always_comb begin
        ins_eop    = 2'b00;
        ins_aluop  = 3'b000;
        ins_alusrc = 1'b0;
        ins_regdst = 2'b00;
        case (ins)
            I_ADDU: ins_regdst = 2'b01;
            I_SUBU: begin ins_regdst = 2'b01; ins_aluop = 3'b001; end
            I_ORI:  begin ins_eop = 2'b01; ins_aluop = 3'b010; ins_alusrc = 1'b1; end
            I_LUI:  begin ins_eop = 2'b10; ins_aluop = 3'b010; ins_alusrc = 1'b1; end
            I_LW,
            I_SW:   ins_alusrc = 1'b1;
            I_BEQ:  begin ins_eop = 2'b11; ins_aluop = 3'b001; end
            default: ;
        endcase
    end

    // Next-state and control outputs; reset forces every enable and select low
    always_comb begin
        st_nxt = FETCH;
        IRWr   = 1'b0;
        PCWr   = 1'b0;
        NPCSel = 2'b00;
        GRFWr  = 1'b0;
        RegDst = 2'b00;
        WDSel  = 2'b00;
        ALUSrc = 1'b0;
        ALUOp  = 3'b000;
        EOp    = 2'b00;
        DMWr   = 1'b0;
        case (st)
            FETCH: begin
                IRWr   = 1'b1;
                PCWr   = 1'b1;
                st_nxt = DECODE;
            end
            DECODE: begin
                EOp = ins_eop;
                case (ins)
                    I_JAL: begin
                        PCWr   = 1'b1;
                        NPCSel = 2'b10;
                        GRFWr  = 1'b1;
                        RegDst = 2'b10;
                        WDSel  = 2'b10;
                    end
                    I_JR: begin
                        PCWr   = 1'b1;
                        NPCSel = 2'b11;
                    end
                    I_NOP:   ;
                    default: st_nxt = EXE;
                endcase
            end
            EXE: begin
                EOp    = ins_eop;
                ALUOp  = ins_aluop;
                ALUSrc = ins_alusrc;
                RegDst = ins_regdst;
                case (ins)
                    I_LW, I_SW: st_nxt = MEM;
                    I_BEQ: begin
                        NPCSel = 2'b01;
                        PCWr   = zero;
                    end
                    I_ADDU, I_SUBU, I_ORI, I_LUI: st_nxt = WB;
                    default: ;
                endcase
            end
            MEM: begin
                EOp    = ins_eop;
                ALUOp  = ins_aluop;
                ALUSrc = ins_alusrc;
                RegDst = ins_regdst;
                DMWr   = (ins == I_SW);
                if (ins == I_LW) st_nxt = WB;
            end
            WB: begin
                EOp    = ins_eop;
                ALUOp  = ins_aluop;
                ALUSrc = ins_alusrc;
                RegDst = ins_regdst;
                GRFWr  = 1'b1;
                WDSel  = (ins == I_LW) ? 2'b01 : 2'b00;
            end
            default: st_nxt = FETCH;
        endcase
        if (reset) begin
            IRWr   = 1'b0;
            PCWr   = 1'b0;
            NPCSel = 2'b00;
            GRFWr  = 1'b0;
            RegDst = 2'b00;
            WDSel  = 2'b00;
            ALUSrc = 1'b0;
            ALUOp  = 3'b000;
            EOp    = 2'b00;
            DMWr   = 1'b0;
        end
    end

    // State register and retired counter (counts every return to FETCH)
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= FETCH;
            retired <= '0;
        end else begin
            st <= st_nxt;
            if (st != FETCH && st_nxt == FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       op = 6'b001101;
    logic [5:0]       funct = 6'b000000;
    logic             zero = 1'b0;
    logic             IRWr, PCWr, GRFWr, ALUSrc, DMWr;
    logic [1:0]       NPCSel, RegDst, WDSel, EOp;
    logic [2:0]       ALUOp, state;
    logic [CNT_W-1:0] retired;

    typedef struct {
        string       tag;
        logic [18:0] vec;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   done       = 1'b0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .IRWr(IRWr), .PCWr(PCWr), .NPCSel(NPCSel), .GRFWr(GRFWr),
        .RegDst(RegDst), .WDSel(WDSel), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .EOp(EOp), .DMWr(DMWr), .state(state), .retired(retired)
    );

    // Output vector: {state, IRWr, PCWr, NPCSel, GRFWr, RegDst, WDSel, ALUSrc, ALUOp, EOp, DMWr}
    function automatic logic [18:0] ev(input int s, input int ir, input int pc, input int npc,
                                       input int grf, input int rd, input int wd, input int as,
                                       input int aop, input int eop, input int dm);
        return {3'(s), 1'(ir), 1'(pc), 2'(npc), 1'(grf), 2'(rd), 2'(wd), 1'(as),
                3'(aop), 2'(eop), 1'(dm)};
    endfunction

    task automatic cyc(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [18:0] v, input int r, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        op    = o;
        funct = f;
        zero  = z;
        e.tag = tag;
        e.vec = v;
        e.ret = 32'(r);
        q.push_back(e);
    endtask

    // Monitor: compare whatever expectation is pending for this cycle
    initial begin
        exp_t        e;
        logic [18:0] act;
        while (!done) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {state, IRWr, PCWr, NPCSel, GRFWr, RegDst, WDSel, ALUSrc, ALUOp, EOp, DMWr};
                compared++;
                if (act !== e.vec || retired !== e.ret) begin
                    mismatched++;
                    $display("FAIL %s: outputs=%05h retired=%0d, expected outputs=%05h retired=%0d",
                             e.tag, act, retired, e.vec, e.ret);
                end
            end
        end
    end

    localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_JAL = 6'h03, OP_BAD = 6'h3F;

    initial begin
        // reset held three cycles with ori on the bus
        for (int i = 0; i < 3; i++)
            cyc(1, OP_ORI, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0), 0, "reset");
        // ori
        cyc(0, OP_ORI, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 0, "ori_fetch");
        cyc(0, OP_ORI, 0, 0, ev(1,0,0,0,0,0,0,0,0,1,0), 0, "ori_decode");
        cyc(0, OP_ORI, 0, 0, ev(2,0,0,0,0,0,0,1,2,1,0), 0, "ori_exe");
        cyc(0, OP_ORI, 0, 0, ev(4,0,0,0,1,0,0,1,2,1,0), 0, "ori_wb");
        // lw
        cyc(0, OP_LW, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 1, "lw_fetch");
        cyc(0, OP_LW, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0), 1, "lw_decode");
        cyc(0, OP_LW, 0, 0, ev(2,0,0,0,0,0,0,1,0,0,0), 1, "lw_exe");
        cyc(0, OP_LW, 0, 0, ev(3,0,0,0,0,0,0,1,0,0,0), 1, "lw_mem");
        cyc(0, OP_LW, 0, 0, ev(4,0,0,0,1,0,1,1,0,0,0), 1, "lw_wb");
        // sw
        cyc(0, OP_SW, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 2, "sw_fetch");
        cyc(0, OP_SW, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0), 2, "sw_decode");
        cyc(0, OP_SW, 0, 0, ev(2,0,0,0,0,0,0,1,0,0,0), 2, "sw_exe");
        cyc(0, OP_SW, 0, 0, ev(3,0,0,0,0,0,0,1,0,0,1), 2, "sw_mem");
        // beq taken, then not taken (zero high in DECODE must be ignored)
        cyc(0, OP_BEQ, 0, 1, ev(0,1,1,0,0,0,0,0,0,0,0), 3, "beq1_fetch");
        cyc(0, OP_BEQ, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0), 3, "beq1_decode");
        cyc(0, OP_BEQ, 0, 1, ev(2,0,1,1,0,0,0,0,1,3,0), 3, "beq1_exe");
        cyc(0, OP_BEQ, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 4, "beq0_fetch");
        cyc(0, OP_BEQ, 0, 1, ev(1,0,0,0,0,0,0,0,0,3,0), 4, "beq0_decode");
        cyc(0, OP_BEQ, 0, 0, ev(2,0,0,1,0,0,0,0,1,3,0), 4, "beq0_exe");
        // jal, jr
        cyc(0, OP_JAL, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 5, "jal_fetch");
        cyc(0, OP_JAL, 0, 0, ev(1,0,1,2,1,2,2,0,0,0,0), 5, "jal_decode");
        cyc(0, OP_R, 6'h08, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 6, "jr_fetch");
        cyc(0, OP_R, 6'h08, 0, ev(1,0,1,3,0,0,0,0,0,0,0), 6, "jr_decode");
        // addu, subu
        cyc(0, OP_R, 6'h21, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 7, "addu_fetch");
        cyc(0, OP_R, 6'h21, 0, ev(1,0,0,0,0,0,0,0,0,0,0), 7, "addu_decode");
        cyc(0, OP_R, 6'h21, 0, ev(2,0,0,0,0,1,0,0,0,0,0), 7, "addu_exe");
        cyc(0, OP_R, 6'h21, 0, ev(4,0,0,0,1,1,0,0,0,0,0), 7, "addu_wb");
        cyc(0, OP_R, 6'h23, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 8, "subu_fetch");
        cyc(0, OP_R, 6'h23, 0, ev(1,0,0,0,0,0,0,0,0,0,0), 8, "subu_decode");
        cyc(0, OP_R, 6'h23, 0, ev(2,0,0,0,0,1,0,0,1,0,0), 8, "subu_exe");
        cyc(0, OP_R, 6'h23, 0, ev(4,0,0,0,1,1,0,0,1,0,0), 8, "subu_wb");
        // unsupported opcode
        cyc(0, OP_BAD, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 9, "bad_fetch");
        cyc(0, OP_BAD, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0), 9, "bad_decode");
        // sw abandoned by reset in MEM
        cyc(0, OP_SW, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 10, "swr_fetch");
        cyc(0, OP_SW, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0), 10, "swr_decode");
        cyc(0, OP_SW, 0, 0, ev(2,0,0,0,0,0,0,1,0,0,0), 10, "swr_exe");
        cyc(1, OP_SW, 0, 0, ev(3,0,0,0,0,0,0,0,0,0,0), 10, "swr_mem_reset");
        cyc(0, OP_SW, 0, 0, ev(0,1,1,0,0,0,0,0,0,0,0), 0, "post_reset_fetch");
        cyc(0, OP_SW, 0, 0, ev(1,0,0,0,0,0,0,0,0,0,0), 0, "post_reset_decode");

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        done = 1'b1;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
